clz_iter: RTL and testbench

Iterative count-leading-zeros unit for the Zbb `clz` path of the pipelined core. It is the MSB-first counterpart of the single-cycle trailing-zeros counter. It trades latency for area by scanning one nibble per cycle from the most significant end and terminating early at the first nonzero nibble. It sits beside the ALU as a multi-cycle functional unit with valid/ready handshakes on both sides and a pipeline flush input.

---
 rtl/clz_iter.sv | 90 +++++++++
 tb/tb_clz_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clz_iter.sv
// Iterative count-leading-zeros unit: scans one nibble per cycle from the MSB
// and stops at the first nonzero nibble. Valid/ready on both sides, sync flush.
module clz_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    res
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh;
    logic [RW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [3:0]       nib;
    logic [1:0]       lz;

    assign nib = sh[WIDTH-1:WIDTH-4];

    always_comb begin
        lz = 2'd3;
        casez (nib)
            4'b1???: lz = 2'd0;
            4'b01??: lz = 2'd1;
            4'b001?: lz = 2'd2;
            default: lz = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh    <= x;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (nib != 4'd0) begin
                        cnt   <= cnt + RW'(lz);
                        state <= DONE;
                    end else begin
                        // All-zero nibble: the final one brings cnt to exactly WIDTH
                        cnt <= cnt + RW'(4);
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            sh  <= sh << 4;
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign res       = cnt;

endmodule

// File: tb/tb_clz_iter.sv
// Directed self-checking bench for clz_iter (WIDTH=32): latency, result,
// backpressure, flush and asynchronous reset behaviour.
module tb_clz_iter;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  res;

    int checks;
    int failures;

    clz_iter #(.WIDTH(32), .RW(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept(input logic [31:0] v);
        in_valid = 1'b1;
        x        = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; capped at 20.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (res !== 6'd0) begin failures++; $display("FAIL reset_res got=%0d exp=0", res); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fast_path;
        int lat;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fast_pre_ready got=%b exp=1", in_ready); end
        accept(32'h8000_0000);
        wait_result(lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL fast_latency got=%0d exp=1", lat); end
        checks++; if (res !== 6'd0) begin failures++; $display("FAIL fast_res got=%0d exp=0", res); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fast_done_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fast_idle_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fast_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_midword;
        int lat;
        accept(32'h0001_0000);
        wait_result(lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL mid16_latency got=%0d exp=4", lat); end
        checks++; if (res !== 6'd15) begin failures++; $display("FAIL mid16_res got=%0d exp=15", res); end
        @(posedge clk);
        #1;
        accept(32'h0000_000F);
        wait_result(lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL lowF_latency got=%0d exp=8", lat); end
        checks++; if (res !== 6'd28) begin failures++; $display("FAIL lowF_res got=%0d exp=28", res); end
        @(posedge clk);
        #1;
        accept(32'h0000_0100);
        wait_result(lat);
        checks++; if (lat !== 6) begin failures++; $display("FAIL mid8_latency got=%0d exp=6", lat); end
        checks++; if (res !== 6'd23) begin failures++; $display("FAIL mid8_res got=%0d exp=23", res); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero;
        int lat;
        int bad_ready;
        accept(32'h0000_0000);
        // Offer a competing operand and a changing x throughout the scan.
        in_valid  = 1'b1;
        x         = 32'hFFFF_FFFF;
        lat       = 0;
        bad_ready = 0;
        do begin
            if (in_ready !== 1'b0) bad_ready++;
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        checks++; if (bad_ready !== 0) begin failures++; $display("FAIL zero_ready_during_scan got=%0d exp=0", bad_ready); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL zero_latency got=%0d exp=8", lat); end
        checks++; if (res !== 6'd32) begin failures++; $display("FAIL zero_res got=%0d exp=32", res); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL zero_done_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL zero_idle_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        accept(32'h00F0_0000);
        wait_result(lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (res !== 6'd8) begin failures++; $display("FAIL bp_hold_res cyc=%0d got=%0d exp=8", i, res); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        checks++; if (res !== 6'd8) begin failures++; $display("FAIL bp_res_after got=%0d exp=8", res); end
    endtask

    task automatic test_flush;
        int lat;
        int bad_valid;
        accept(32'h0000_0000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        bad_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) bad_valid++;
            @(posedge clk);
            #1;
        end
        checks++; if (bad_valid !== 0) begin failures++; $display("FAIL flush_no_valid got=%0d exp=0", bad_valid); end
        // Operand offered together with flush in IDLE must be dropped.
        in_valid = 1'b1;
        flush    = 1'b1;
        x        = 32'h0000_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_blocks_accept got=%b exp=1", in_ready); end
        accept(32'h4000_0000);
        wait_result(lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL post_flush_latency got=%0d exp=1", lat); end
        checks++; if (res !== 6'd1) begin failures++; $display("FAIL post_flush_res got=%0d exp=1", res); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset;
        int lat;
        accept(32'h0000_0001);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        checks++; if (res !== 6'd0) begin failures++; $display("FAIL areset_res got=%0d exp=0", res); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        accept(32'h0000_0100);
        wait_result(lat);
        checks++; if (lat !== 6) begin failures++; $display("FAIL post_reset_latency got=%0d exp=6", lat); end
        checks++; if (res !== 6'd23) begin failures++; $display("FAIL post_reset_res got=%0d exp=23", res); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_fast_path;
        test_midword;
        test_zero;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
